// File: rtl/matrix_pkg.sv
// Shared matrix RAM constants, read/write encoding and arbiter state encoding.
package matrix_pkg;
  localparam int DW = 256;
  localparam int AW = 4;

  typedef enum logic {
    WRITE = 1'b0,
    READ  = 1'b1
  } rw_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_t;
endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie the port not served last wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  // last = 1 means port 1 was served most recently
  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || last)) gnt = 2'b01;
    else if (req[1])                 gnt = 2'b10;
  end
endmodule

// File: rtl/mat_ram_arbiter.sv
// Serializes one-word read/write commands from the exe engine (A) and host loader (B) onto the matrix RAM.
module mat_ram_arbiter #(
  parameter int DW  = matrix_pkg::DW,
  parameter int AW  = matrix_pkg::AW,
  parameter int LAT = 3
) (
  input  logic          Clock,
  input  logic          Reset_n,
  input  logic          ReqA,
  input  logic          ReqB,
  input  logic          RwA,
  input  logic          RwB,
  input  logic [AW-1:0] AddrA,
  input  logic [AW-1:0] AddrB,
  input  logic [DW-1:0] WDataA,
  input  logic [DW-1:0] WDataB,
  output logic          GrantA,
  output logic          GrantB,
  output logic          DoneA,
  output logic          DoneB,
  output logic [DW-1:0] RDataA,
  output logic [DW-1:0] RDataB,
  output logic          Busy,
  output logic          RamEnable,
  output logic          RamReadWrite,
  output logic [AW-1:0] RamAddress,
  output logic [DW-1:0] RamDataOut,
  input  logic [DW-1:0] RamDataIn
);
  import matrix_pkg::*;

  localparam int CW = $clog2(LAT) + 1;

  arb_state_t    state, state_nxt;
  logic [CW-1:0] cnt;
  logic          owner_b;
  logic          last_b;
  logic          cmd_rw;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [DW-1:0] rdata_a, rdata_b;
  logic [1:0]    gnt;
  logic          last_cyc;

  rr_pick2 u_pick (
    .req  ({ReqB, ReqA}),
    .last (last_b),
    .gnt  (gnt)
  );

  assign last_cyc = (cnt == CW'(LAT - 1));

  always_ff @(posedge Clock) begin
    if (!Reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (|gnt)     state_nxt = ST_ACCESS;
      ST_ACCESS: if (last_cyc) state_nxt = ST_DONE;
      ST_DONE:                 state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  // Command latch, access counter, read-data capture and round-robin history
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      cnt       <= '0;
      owner_b   <= 1'b0;
      last_b    <= 1'b1;
      cmd_rw    <= READ;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      rdata_a   <= '0;
      rdata_b   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|gnt) begin
            owner_b   <= gnt[1];
            cmd_rw    <= gnt[1] ? RwB    : RwA;
            cmd_addr  <= gnt[1] ? AddrB  : AddrA;
            cmd_wdata <= gnt[1] ? WDataB : WDataA;
            cnt       <= '0;
          end
        end
        ST_ACCESS: begin
          cnt <= cnt + CW'(1);
          if (last_cyc && cmd_rw == READ) begin
            if (owner_b) rdata_b <= RamDataIn;
            else         rdata_a <= RamDataIn;
          end
        end
        ST_DONE: last_b <= owner_b;
        default: ;
      endcase
    end
  end

  always_comb begin
    Busy         = (state != ST_IDLE);
    RamEnable    = (state == ST_ACCESS);
    GrantA       = (state == ST_ACCESS || state == ST_DONE) && !owner_b;
    GrantB       = (state == ST_ACCESS || state == ST_DONE) &&  owner_b;
    DoneA        = (state == ST_DONE) && !owner_b;
    DoneB        = (state == ST_DONE) &&  owner_b;
    RamReadWrite = cmd_rw;
    RamAddress   = cmd_addr;
    RamDataOut   = cmd_wdata;
    RDataA       = rdata_a;
    RDataB       = rdata_b;
  end
endmodule

// File: tb/tb_mat_ram_arbiter.sv
// Directed plus randomized bench for mat_ram_arbiter against a transaction-level model.
module tb_mat_ram_arbiter;
  localparam int DW  = 256;
  localparam int AW  = 4;
  localparam int LAT = 3;

  logic          Clock = 1'b0;
  logic          Reset_n;
  logic          ReqA, ReqB, RwA, RwB;
  logic [AW-1:0] AddrA, AddrB;
  logic [DW-1:0] WDataA, WDataB;
  logic          GrantA, GrantB, DoneA, DoneB;
  logic [DW-1:0] RDataA, RDataB;
  logic          Busy, RamEnable, RamReadWrite;
  logic [AW-1:0] RamAddress;
  logic [DW-1:0] RamDataOut, RamDataIn;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: who wins a tie next, and what each port's read register holds
  bit            a_tie;
  logic [DW-1:0] rda, rdb;

  mat_ram_arbiter #(.DW(DW), .AW(AW), .LAT(LAT)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .ReqA(ReqA), .ReqB(ReqB), .RwA(RwA), .RwB(RwB),
    .AddrA(AddrA), .AddrB(AddrB), .WDataA(WDataA), .WDataB(WDataB),
    .GrantA(GrantA), .GrantB(GrantB), .DoneA(DoneA), .DoneB(DoneB),
    .RDataA(RDataA), .RDataB(RDataB), .Busy(Busy),
    .RamEnable(RamEnable), .RamReadWrite(RamReadWrite),
    .RamAddress(RamAddress), .RamDataOut(RamDataOut), .RamDataIn(RamDataIn)
  );

  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".busy"},  DW'(Busy), '0);
    chk({tag, ".ramen"}, DW'(RamEnable), '0);
    chk({tag, ".gnta"},  DW'(GrantA), '0);
    chk({tag, ".gntb"},  DW'(GrantB), '0);
    chk({tag, ".donea"}, DW'(DoneA), '0);
    chk({tag, ".doneb"}, DW'(DoneB), '0);
    chk({tag, ".rda"},   RDataA, rda);
    chk({tag, ".rdb"},   RDataB, rdb);
  endtask

  // Called in an IDLE cycle with at least one request driven; ends in the following IDLE cycle.
  task automatic do_access(input string tag, input bit disturb);
    bit            isb;
    logic          erw;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] ewd, erd;
    isb   = (ReqA && ReqB) ? !a_tie : ReqB;
    erw   = isb ? RwB : RwA;
    eaddr = isb ? AddrB : AddrA;
    ewd   = isb ? WDataB : WDataA;
    erd   = '0;
    step();
    for (int k = 1; k <= LAT; k++) begin
      chk({tag, ".acc.ramen"}, DW'(RamEnable), DW'(1'b1));
      chk({tag, ".acc.busy"},  DW'(Busy), DW'(1'b1));
      chk({tag, ".acc.rw"},    DW'(RamReadWrite), DW'(erw));
      chk({tag, ".acc.addr"},  DW'(RamAddress), DW'(eaddr));
      chk({tag, ".acc.wdata"}, RamDataOut, ewd);
      chk({tag, ".acc.gnta"},  DW'(GrantA), DW'(!isb));
      chk({tag, ".acc.gntb"},  DW'(GrantB), DW'(isb));
      chk({tag, ".acc.done"},  DW'(DoneA | DoneB), '0);
      RamDataIn = rnd_word();
      if (k == LAT) erd = RamDataIn;
      if (disturb) begin
        ReqA  = 1'($urandom_range(0, 1));
        ReqB  = 1'($urandom_range(0, 1));
        RwA   = ~RwA;
        RwB   = ~RwB;
        AddrA = AddrA + 4'd3;
        AddrB = AddrB + 4'd7;
        WDataA = rnd_word();
        WDataB = rnd_word();
      end
      step();
    end
    if (erw) begin
      if (isb) rdb = erd;
      else     rda = erd;
    end
    chk({tag, ".done.ramen"}, DW'(RamEnable), '0);
    chk({tag, ".done.busy"},  DW'(Busy), DW'(1'b1));
    chk({tag, ".done.gnta"},  DW'(GrantA), DW'(!isb));
    chk({tag, ".done.gntb"},  DW'(GrantB), DW'(isb));
    chk({tag, ".done.donea"}, DW'(DoneA), DW'(!isb));
    chk({tag, ".done.doneb"}, DW'(DoneB), DW'(isb));
    chk({tag, ".done.rda"},   RDataA, rda);
    chk({tag, ".done.rdb"},   RDataB, rdb);
    a_tie = isb;
    step();
    check_idle({tag, ".post"});
  endtask

  initial begin
    Reset_n = 1'b0;
    ReqA = 1'b1; ReqB = 1'b0; RwA = 1'b1; RwB = 1'b1;
    AddrA = 4'h5; AddrB = 4'h0;
    WDataA = '0; WDataB = '0; RamDataIn = '0;
    a_tie = 1'b1; rda = '0; rdb = '0;

    for (int i = 0; i < 3; i++) begin
      step();
      check_idle("reset");
      chk("reset.rw",    DW'(RamReadWrite), DW'(1'b1));
      chk("reset.addr",  DW'(RamAddress), '0);
      chk("reset.wdata", RamDataOut, '0);
    end

    // Single read on A, request held since reset
    Reset_n = 1'b1;
    do_access("readA", 1'b0);

    // Single write on B
    ReqA = 1'b0; ReqB = 1'b1; RwB = 1'b0; AddrB = 4'hA; WDataB = rnd_word();
    do_access("writeB", 1'b0);

    // Both requesting continuously: A,B,A,B
    ReqA = 1'b1; ReqB = 1'b1; RwA = 1'b1; RwB = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("contend.order", DW'(a_tie), DW'((i % 2) == 0));
      AddrA = 4'(i); AddrB = 4'(i + 8);
      do_access("contend", 1'b0);
    end

    // Request dropped and command changed mid-access
    ReqA = 1'b1; ReqB = 1'b0; RwA = 1'b0; AddrA = 4'h6; WDataA = rnd_word();
    do_access("drop", 1'b1);

    // Reset during the second access cycle; B holds the tie priority beforehand
    ReqA = 1'b1; ReqB = 1'b1; RwA = 1'b1; RwB = 1'b1;
    step();
    chk("rstmid.ramen", DW'(RamEnable), DW'(1'b1));
    chk("rstmid.gntb",  DW'(GrantB), DW'(!a_tie));
    RamDataIn = rnd_word();
    step();
    Reset_n = 1'b0;
    step();
    rda = '0; rdb = '0; a_tie = 1'b1;
    check_idle("rstmid.after");
    Reset_n = 1'b1;
    do_access("rstmid.tie", 1'b0);

    // Randomized traffic with idle gaps and mid-access disturbance
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        ReqA = 1'b0; ReqB = 1'b0;
        step();
        check_idle("rand.idle");
      end
      case ($urandom_range(0, 2))
        0:       begin ReqA = 1'b1; ReqB = 1'b0; end
        1:       begin ReqA = 1'b0; ReqB = 1'b1; end
        default: begin ReqA = 1'b1; ReqB = 1'b1; end
      endcase
      RwA = 1'($urandom_range(0, 1)); RwB = 1'($urandom_range(0, 1));
      AddrA = 4'($urandom); AddrB = 4'($urandom);
      WDataA = rnd_word(); WDataB = rnd_word();
      do_access("rand", 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
